// File: rtl/anspwm_mc.sv
// Multi-channel noise-shaped PWM: one shared error-feedback quantiser visits channel i at cnt==i.
// Define ANSPWM_DITHER_EN to add LFSR dither to the quantiser input.
module anspwm_mc #(
    parameter int NCH   = 4,
    parameter int IN_W  = 32,
    parameter int OUT_W = 8,
    parameter int ORDER = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH*IN_W-1:0]   tgt_in,
    input  logic                  tgt_valid,
    output logic                  tgt_ready,
    output logic [NCH-1:0]        pwm_out,
    output logic [NCH*OUT_W-1:0]  duty_out,
    output logic                  frame_out
);

    localparam int F  = IN_W - OUT_W;
    localparam int TW = IN_W + 3;
    localparam logic [OUT_W-1:0] MAX = '1;

    logic [OUT_W-1:0]     cnt;
    logic [NCH*IN_W-1:0]  inbuf;
    logic [NCH*IN_W-1:0]  work;
    logic                 buf_full;
    logic [OUT_W-1:0]     duty   [NCH];
    logic [OUT_W-1:0]     shadow [NCH];
    logic [F-1:0]         e1     [NCH];
    logic [F-1:0]         e2     [NCH];

    logic                 at_max;
    logic                 accept;
    logic                 vld_p0;
    logic [IN_W-1:0]      work_p0;
    logic [F-1:0]         e1_p0;
    logic [F-1:0]         e2_p0;
    logic signed [TW-1:0] fb_p0;
    logic signed [TW-1:0] dith_p0;
    logic signed [TW-1:0] t_p0;
    logic [IN_W-1:0]      ts_p0;
    logic [OUT_W-1:0]     q_p0;
    logic [F-1:0]         err_p0;

    // Clamp to [0, 2**IN_W-1]; the sum never wraps.
    function automatic logic [IN_W-1:0] sat_in(input logic signed [TW-1:0] v);
        if (v[TW-1])
            return '0;
        else if (|v[TW-2:IN_W])
            return '1;
        else
            return v[IN_W-1:0];
    endfunction

    assign at_max    = (cnt == MAX);
    assign tgt_ready = !buf_full || at_max;
    assign accept    = tgt_valid && tgt_ready;
    assign frame_out = (cnt == '0);

    always_comb begin
        for (int i = 0; i < NCH; i++)
            duty_out[i*OUT_W +: OUT_W] = duty[i];
    end

    // Stage p0: select the channel owning this slot and requantise it.
    always_comb begin
        vld_p0  = 1'b0;
        work_p0 = '0;
        e1_p0   = '0;
        e2_p0   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cnt == OUT_W'(i)) begin
                vld_p0  = 1'b1;
                work_p0 = work[i*IN_W +: IN_W];
                e1_p0   = e1[i];
                e2_p0   = e2[i];
            end
        end
        if (ORDER == 2)
            fb_p0 = ($signed(TW'(e1_p0)) <<< 1) - $signed(TW'(e2_p0));
        else
            fb_p0 = $signed(TW'(e1_p0));
    end

`ifdef ANSPWM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= 16'hACE1;
        else if (vld_p0)
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign dith_p0 = $signed(TW'(lfsr[F-2:0])) - $signed(TW'(2 ** (F - 2)));
`else
    assign dith_p0 = '0;
`endif

    assign t_p0   = $signed(TW'(work_p0)) + fb_p0 + dith_p0;
    assign ts_p0  = sat_in(t_p0);
    assign q_p0   = ts_p0[IN_W-1 -: OUT_W];
    assign err_p0 = ts_p0[F-1:0];

    // Stage p1: channel state, buffer handshake and PWM compare registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            buf_full <= 1'b0;
            inbuf    <= '0;
            work     <= '0;
            pwm_out  <= '0;
            for (int i = 0; i < NCH; i++) begin
                duty[i]   <= '0;
                shadow[i] <= '0;
                e1[i]     <= '0;
                e2[i]     <= '0;
            end
        end else begin
            cnt <= cnt + 1'b1;
            if (at_max) begin
                if (buf_full)
                    work <= inbuf;
                for (int i = 0; i < NCH; i++)
                    duty[i] <= shadow[i];
            end
            // A snapshot-cycle accept refills the slot the snapshot just drained.
            if (accept) begin
                inbuf    <= tgt_in;
                buf_full <= 1'b1;
            end else if (at_max) begin
                buf_full <= 1'b0;
            end
            for (int i = 0; i < NCH; i++) begin
                if (cnt == OUT_W'(i)) begin
                    shadow[i] <= q_p0;
                    e2[i]     <= e1[i];
                    e1[i]     <= err_p0;
                end
                pwm_out[i] <= (cnt < duty[i]);
            end
        end
    end

endmodule

// File: tb/tb_anspwm_mc.sv
// Bench for anspwm_mc: ORDER=1 and ORDER=2 instances, vector table plus scoreboard of per-period duties.
module tb_anspwm_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tgt_in = '0;
    logic [63:0] tgt_in2 = '0;
    logic        tgt_valid = 1'b0;
    logic        tgt_valid2 = 1'b0;
    logic        tgt_ready, tgt_ready2;
    logic [3:0]  pwm_out, pwm_out2;
    logic [31:0] duty_out, duty_out2;
    logic        frame_out, frame_out2;

    always #5 clk = ~clk;

    anspwm_mc #(.NCH(4), .IN_W(16), .OUT_W(8), .ORDER(1)) dut (
        .clk(clk), .rst(rst), .tgt_in(tgt_in), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .pwm_out(pwm_out), .duty_out(duty_out), .frame_out(frame_out)
    );

    anspwm_mc #(.NCH(4), .IN_W(16), .OUT_W(8), .ORDER(2)) dut2 (
        .clk(clk), .rst(rst), .tgt_in(tgt_in2), .tgt_valid(tgt_valid2), .tgt_ready(tgt_ready2),
        .pwm_out(pwm_out2), .duty_out(duty_out2), .frame_out(frame_out2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bench-side period position, tracking cnt from reset.
    logic [7:0] bcnt = '0;
    int         per = 0;
    logic       started = 1'b0;
    int         phase = 0;

    always @(posedge clk) begin
        if (rst) begin
            bcnt <= '0;
            per  <= 0;
        end else begin
            bcnt <= bcnt + 8'd1;
            if (bcnt == 8'hFF)
                per <= per + 1;
        end
    end

    typedef struct {
        int          due;
        logic [31:0] duty;
    } exp_t;
    exp_t sb[$];
    exp_t cur;

    typedef struct {
        logic [63:0] inp;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[8];

    // ORDER=2 instance sees one sample {0, FFFF, 0180, 8000} in period 0 and holds it.
    function automatic logic [31:0] exp2(input int p);
        logic [7:0] s1;
        if (p < 2)
            return 32'h0;
        s1 = (((p - 2) % 4) == 0 || ((p - 2) % 4) == 3) ? 8'd1 : 8'd2;
        return {8'h00, 8'hFF, s1, 8'h80};
    endfunction

    int          acc [4] = '{0, 0, 0, 0};
    int          acc2[4] = '{0, 0, 0, 0};
    logic        pend = 1'b0;
    logic [31:0] pexp = '0;
    logic [31:0] e2v;

    always @(negedge clk) begin
        if (started && !rst) begin
            check($sformatf("frame p%0d c%0d", per, bcnt), {63'b0, frame_out}, {63'b0, bcnt == 8'd0});
            if (bcnt == 8'd1) begin
                for (int i = 0; i < 4; i++) begin
                    acc[i]  = 0;
                    acc2[i] = 0;
                end
                if (sb.size() > 0 && sb[0].due == per) begin
                    cur = sb.pop_front();
                    check($sformatf("duty p%0d", per), {32'b0, duty_out}, {32'b0, cur.duty});
                    pend = 1'b1;
                    pexp = cur.duty;
                end
                if (phase == 0 && per <= 9)
                    check($sformatf("duty2 p%0d", per), {32'b0, duty_out2}, {32'b0, exp2(per)});
            end
            for (int i = 0; i < 4; i++) begin
                acc[i]  = acc[i] + int'(pwm_out[i]);
                acc2[i] = acc2[i] + int'(pwm_out2[i]);
            end
            if (bcnt == 8'd0) begin
                if (pend) begin
                    for (int i = 0; i < 4; i++)
                        check($sformatf("pwm highs ch%0d p%0d", i, per - 1), 64'(acc[i]), {56'b0, pexp[i*8 +: 8]});
                    pend = 1'b0;
                end
                if (phase == 0 && per >= 1 && per <= 10) begin
                    e2v = exp2(per - 1);
                    for (int i = 0; i < 4; i++)
                        check($sformatf("pwm2 highs ch%0d p%0d", i, per - 1), 64'(acc2[i]), {56'b0, e2v[i*8 +: 8]});
                end
            end
        end else begin
            pend = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_pos(input int p, input logic [7:0] c);
        while (!(per == p && bcnt == c)) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pwm"},   {60'b0, pwm_out},   64'h0);
        check({tag, " duty"},  {32'b0, duty_out},  64'h0);
        check({tag, " ready"}, {63'b0, tgt_ready}, 64'h1);
        check({tag, " frame"}, {63'b0, frame_out}, 64'h1);
    endtask

    initial begin
        vt[0] = '{64'h0000_FFFF_0180_8000, 32'h00_FF_01_80};
        vt[1] = '{64'h0000_FFFF_0180_8000, 32'h00_FF_02_80};
        vt[2] = '{64'h0000_FFFF_0180_8000, 32'h00_FF_01_80};
        vt[3] = '{64'h00FF_0010_0180_1234, 32'h00_01_02_12};
        vt[4] = '{64'h00FF_0010_0180_1234, 32'h01_00_01_12};
        vt[5] = '{64'h00FF_0010_0180_1234, 32'h01_00_02_12};
        vt[6] = '{64'h00FF_0010_0180_1234, 32'h01_00_01_12};
        vt[7] = '{64'h00FF_0010_0180_1234, 32'h01_00_02_13};

        sb.push_back('{0, 32'h0});
        sb.push_back('{1, 32'h0});

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        started = 1'b1;
        check_reset_state("reset");

        for (int j = 0; j < 8; j++) begin
            wait_pos(j, 8'd0);
            tgt_in    = vt[j].inp;
            tgt_valid = 1'b1;
            check($sformatf("ready empty v%0d", j), {63'b0, tgt_ready}, 64'h1);
            if (j == 0) begin
                tgt_in2    = 64'h0000_FFFF_0180_8000;
                tgt_valid2 = 1'b1;
                check("ready2 empty", {63'b0, tgt_ready2}, 64'h1);
            end
            sb.push_back('{j + 2, vt[j].exp});
            @(negedge clk);
            tgt_valid  = 1'b0;
            tgt_valid2 = 1'b0;
            check($sformatf("ready full v%0d", j), {63'b0, tgt_ready}, 64'h0);
        end

        // Backpressure: valid held with A, B, C across two snapshot edges.
        wait_pos(10, 8'd5);
        phase = 1;
        check("sb drained vec", 64'(sb.size()), 64'h0);
        sb.push_back('{12, 32'h44332211});
        sb.push_back('{13, 32'h88776655});
        sb.push_back('{14, 32'h010203FE});
        sb.push_back('{15, 32'h010203FE});
        tgt_in    = 64'h4400_3300_2200_1100;
        tgt_valid = 1'b1;
        check("bp A ready", {63'b0, tgt_ready}, 64'h1);
        @(negedge clk);
        check("bp B stalled", {63'b0, tgt_ready}, 64'h0);
        tgt_in = 64'h8800_7700_6600_5500;
        while (bcnt != 8'hFF) @(negedge clk);
        check("bp B ready at max", {63'b0, tgt_ready}, 64'h1);
        @(negedge clk);
        check("bp C stalled", {63'b0, tgt_ready}, 64'h0);
        tgt_in = 64'h0100_0200_0300_FE00;
        while (bcnt != 8'hFF) @(negedge clk);
        check("bp C ready at max", {63'b0, tgt_ready}, 64'h1);
        @(negedge clk);
        tgt_valid = 1'b0;
        check("bp C buffered", {63'b0, tgt_ready}, 64'h0);

        // Mid-period reset with non-zero duties, then error state must start from zero.
        wait_pos(16, 8'd100);
        check("sb drained bp", 64'(sb.size()), 64'h0);
        check("duty before reset", {32'b0, duty_out}, 64'h010203FE);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("mid reset");
        sb.push_back('{0, 32'h0});
        sb.push_back('{1, 32'h0});
        sb.push_back('{2, 32'h00_00_01_80});
        sb.push_back('{3, 32'h01_00_02_80});
        tgt_in    = 64'h00FF_0000_0180_8000;
        tgt_valid = 1'b1;
        check("ready after reset", {63'b0, tgt_ready}, 64'h1);
        @(negedge clk);
        tgt_valid = 1'b0;

        wait_pos(4, 8'd5);
        check("sb drained end", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
